// File: rtl/load_return_unit.sv
// Load return unit: issues a word-aligned bus read for a load, then extracts and extends the addressed byte/halfword.
// Optional bus watchdog enabled by defining LOAD_TIMEOUT_EN.
module load_return_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic [2:0]  ld_op,
  input  logic        flush,
  output logic        rd_req,
  output logic [31:0] rd_addr,
  input  logic        rd_ack,
  input  logic [31:0] rd_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] data_out,
  output logic        exc_adel,
  output logic        exc_bus
);

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      r_state, w_next;
  logic        r_rd_req, r_done, r_exc_adel, r_exc_bus;
  logic [31:0] r_rd_addr, r_data_out;
  logic [1:0]  r_off;
  logic [2:0]  r_op;
  logic        w_misalign, w_accept, w_bad, w_complete, w_timeout, w_tmo;
  logic [31:0] w_ext;
  logic [15:0] w_half;
  logic [7:0]  w_byte;

  assign w_misalign = ((ld_op == OP_LW) && (addr[1:0] != 2'b00)) ||
                      (((ld_op == OP_LH) || (ld_op == OP_LHU)) && addr[0]) ||
                      (ld_op > OP_LBU);

`ifdef LOAD_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt;

  // Timeout fires on the TIMEOUT-th consecutive WAIT cycle without ack.
  assign w_tmo = (r_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_cnt <= '0;
    else if (w_accept)
      r_cnt <= '0;
    else if (r_state == S_WAIT && !rd_ack)
      r_cnt <= r_cnt + 1'b1;
  end

  assign exc_bus = r_exc_bus;
`else
  assign w_tmo   = 1'b0;
  // Parameters only matter for the watchdog; this folds to constant 0.
  assign exc_bus = r_exc_bus && (CNT_W < 0) && (TIMEOUT < 0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_bad      = 1'b0;
    w_complete = 1'b0;
    w_timeout  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          if (w_misalign) begin
            w_next = S_DONE;
            w_bad  = 1'b1;
          end else begin
            w_next   = S_WAIT;
            w_accept = 1'b1;
          end
        end
      end
      S_WAIT: begin
        // flush beats ack; ack beats timeout
        if (flush) begin
          w_next = S_IDLE;
        end else if (rd_ack) begin
          w_next     = S_DONE;
          w_complete = 1'b1;
        end else if (w_tmo) begin
          w_next    = S_DONE;
          w_timeout = 1'b1;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_half = r_off[1] ? rd_data[31:16] : rd_data[15:0];
    case (r_off)
      2'd0:    w_byte = rd_data[7:0];
      2'd1:    w_byte = rd_data[15:8];
      2'd2:    w_byte = rd_data[23:16];
      default: w_byte = rd_data[31:24];
    endcase
    case (r_op)
      OP_LH:   w_ext = {{16{w_half[15]}}, w_half};
      OP_LHU:  w_ext = {16'h0, w_half};
      OP_LB:   w_ext = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  w_ext = {24'h0, w_byte};
      default: w_ext = rd_data;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_req   <= 1'b0;
      r_rd_addr  <= '0;
      r_off      <= '0;
      r_op       <= '0;
      r_done     <= 1'b0;
      r_exc_adel <= 1'b0;
      r_exc_bus  <= 1'b0;
      r_data_out <= '0;
    end else begin
      r_done     <= w_bad | w_complete | w_timeout;
      r_exc_adel <= w_bad;
      r_exc_bus  <= w_timeout;
      if (w_accept) begin
        r_rd_req  <= 1'b1;
        r_rd_addr <= {addr[31:2], 2'b00};
        r_off     <= addr[1:0];
        r_op      <= ld_op;
      end else if (r_state == S_WAIT && w_next != S_WAIT) begin
        r_rd_req <= 1'b0;
      end
      if (w_complete)
        r_data_out <= w_ext;
      else if (w_bad || w_timeout)
        r_data_out <= '0;
    end
  end

  assign rd_req   = r_rd_req;
  assign rd_addr  = r_rd_addr;
  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign data_out = r_data_out;
  assign exc_adel = r_exc_adel;

endmodule
